// File: rtl/lzw_pkg.sv
// -----------------------------------------------------------------------------
// lzw_pkg
//   Shared types and constants for the GMII payload extractor that feeds
//   lzw_forward_compress.
//   Contents: parser FSM state enum, preamble and SFD byte values.
// -----------------------------------------------------------------------------
package lzw_pkg;

  localparam logic [7:0] C_PRE_BYTE = 8'h55;
  localparam logic [7:0] C_SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_t;

endpackage

// File: rtl/lzw_byte_delay_line.sv
// -----------------------------------------------------------------------------
// lzw_byte_delay_line
//   Byte shift register that withholds the trailing FCS bytes of a frame.
//   A byte only leaves once P_DEPTH newer bytes have arrived behind it, so
//   whatever is still inside when the frame ends is the FCS and is flushed.
// Ports
//   i_clk    in   clock
//   i_rst    in   synchronous reset, active-high (empties the line)
//   i_shift  in   push i_data in; o_data is the oldest byte before the push
//   i_flush  in   discard contents (fill count to zero); wins over i_shift
//   i_data   in   byte to push
//   o_data   out  oldest byte held (meaningful when o_full)
//   o_full   out  line holds P_DEPTH bytes
// -----------------------------------------------------------------------------
module lzw_byte_delay_line #(
  parameter int P_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_shift,
  input  logic       i_flush,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_full
);

  localparam int W_FILL = $clog2(P_DEPTH + 1);

  logic [7:0]        r_mem [P_DEPTH];
  logic [W_FILL-1:0] r_fill;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fill <= '0;
      for (int i = 0; i < P_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_flush) begin
        r_fill <= '0;
      end else if (i_shift && (r_fill != W_FILL'(P_DEPTH))) begin
        r_fill <= r_fill + 1'b1;
      end
      // Contents are not cleared on flush; the fill count alone decides
      // when stale bytes could ever reach o_data, and it never does.
      if (i_shift && !i_flush) begin
        r_mem[0] <= i_data;
        for (int i = 1; i < P_DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_data = r_mem[P_DEPTH-1];
  assign o_full = (r_fill == W_FILL'(P_DEPTH));

endmodule

// File: rtl/lzw_gmii_payload_extract.sv
// -----------------------------------------------------------------------------
// lzw_gmii_payload_extract
//   Parses a raw GMII rx byte stream, strips preamble/SFD, the DA+SA header
//   and the trailing FCS, and forwards only payload bytes to the compressor.
//   Also reports per-frame length and running frame/payload/error counts.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for a dv rising edge
//   PRE    | counting 0x55 preamble bytes, looking for SFD
//   HDR    | dropping DA+SA header bytes
//   PAY    | payload through the FCS withhold line
//   DROP   | malformed frame, ignore until dv falls
//
// Ports
//   I_sys_clk      in   system clock
//   I_sys_rst      in   synchronous reset, active-high
//   I_state_clr    in   pulse: clear the three statistics counters
//   I_gmii_data    in   GMII rx byte
//   I_gmii_dv      in   GMII data valid
//   O_tx_data      out  payload byte to compressor
//   O_tx_data_en   out  payload byte valid
//   O_frame_done   out  1-cycle pulse after each accepted frame
//   O_frame_len    out  payload byte count, valid with O_frame_done
//   O_frame_cnt    out  accepted frames
//   O_payload_cnt  out  payload bytes emitted
//   O_err_cnt      out  aborted/malformed frames
// -----------------------------------------------------------------------------
module lzw_gmii_payload_extract
  import lzw_pkg::*;
#(
  parameter int C_HDR_BYTES = 12,
  parameter int C_MIN_PRE   = 1,
  parameter int C_MAX_PRE   = 7,
  parameter int C_FCS_BYTES = 4,
  parameter int C_LEN_W     = 16
) (
  input  logic               I_sys_clk,
  input  logic               I_sys_rst,
  input  logic               I_state_clr,
  input  logic [7:0]         I_gmii_data,
  input  logic               I_gmii_dv,
  output logic [7:0]         O_tx_data,
  output logic               O_tx_data_en,
  output logic               O_frame_done,
  output logic [C_LEN_W-1:0] O_frame_len,
  output logic [31:0]        O_frame_cnt,
  output logic [31:0]        O_payload_cnt,
  output logic [15:0]        O_err_cnt
);

  localparam int W_PRE = $clog2(C_MAX_PRE + 1);
  localparam int W_HDR = (C_HDR_BYTES > 1) ? $clog2(C_HDR_BYTES) : 1;

  state_t             r_state, w_state_nxt;
  logic [W_PRE-1:0]   r_pre_cnt, w_pre_nxt;
  logic [W_HDR-1:0]   r_hdr_cnt, w_hdr_nxt;
  logic               r_dv_d;
  logic               r_armed;
  logic               w_rise;
  logic               w_shift;
  logic               w_emit;
  logic               w_err_inc;
  logic               w_end_ok;
  logic               w_end_runt;
  logic               w_dl_full;
  logic [7:0]         w_dl_data;
  logic [C_LEN_W-1:0] r_emit_cnt;

  logic [7:0]         r_tx_data;
  logic               r_tx_en;
  logic               r_done;
  logic [C_LEN_W-1:0] r_frame_len;
  logic [31:0]        r_frame_cnt;
  logic [31:0]        r_payload_cnt;
  logic [15:0]        r_err_cnt;

  // r_armed stays low until dv has been seen low once after reset, so a
  // frame already in flight when reset releases is never mistaken for a
  // new rising edge.
  assign w_rise  = I_gmii_dv && !r_dv_d && r_armed;
  assign w_shift = (r_state == S_PAY) && I_gmii_dv;
  assign w_emit  = w_shift && w_dl_full;

  lzw_byte_delay_line #(
    .P_DEPTH (C_FCS_BYTES)
  ) u_fcs_line (
    .i_clk   (I_sys_clk),
    .i_rst   (I_sys_rst),
    .i_shift (w_shift),
    .i_flush (!w_shift),
    .i_data  (I_gmii_data),
    .o_data  (w_dl_data),
    .o_full  (w_dl_full)
  );

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre_cnt;
    w_hdr_nxt   = r_hdr_cnt;
    w_err_inc   = 1'b0;
    w_end_ok    = 1'b0;
    w_end_runt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          if (I_gmii_data == C_PRE_BYTE) begin
            w_state_nxt = S_PRE;
            w_pre_nxt   = W_PRE'(1);
          end else begin
            w_state_nxt = S_DROP;
            w_err_inc   = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (!I_gmii_dv) begin
          w_state_nxt = S_IDLE;
          w_err_inc   = 1'b1;
        end else if (I_gmii_data == C_PRE_BYTE) begin
          // One more 0x55 would exceed the allowed preamble length.
          if (r_pre_cnt == W_PRE'(C_MAX_PRE)) begin
            w_state_nxt = S_DROP;
            w_err_inc   = 1'b1;
          end else begin
            w_pre_nxt = r_pre_cnt + 1'b1;
          end
        end else if ((I_gmii_data == C_SFD_BYTE) && (r_pre_cnt >= W_PRE'(C_MIN_PRE))) begin
          w_state_nxt = S_HDR;
          w_hdr_nxt   = '0;
        end else begin
          w_state_nxt = S_DROP;
          w_err_inc   = 1'b1;
        end
      end
      S_HDR: begin
        if (!I_gmii_dv) begin
          w_state_nxt = S_IDLE;
          w_err_inc   = 1'b1;
        end else if (r_hdr_cnt == W_HDR'(C_HDR_BYTES - 1)) begin
          w_state_nxt = S_PAY;
        end else begin
          w_hdr_nxt = r_hdr_cnt + 1'b1;
        end
      end
      S_PAY: begin
        if (!I_gmii_dv) begin
          w_state_nxt = S_IDLE;
          if (r_emit_cnt != '0) begin
            w_end_ok = 1'b1;
          end else begin
            w_end_runt = 1'b1;
            w_err_inc  = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (!I_gmii_dv) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      r_pre_cnt     <= '0;
      r_hdr_cnt     <= '0;
      r_dv_d        <= 1'b0;
      r_armed       <= 1'b0;
      r_emit_cnt    <= '0;
      r_tx_data     <= '0;
      r_tx_en       <= 1'b0;
      r_done        <= 1'b0;
      r_frame_len   <= '0;
      r_frame_cnt   <= '0;
      r_payload_cnt <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_hdr_cnt <= w_hdr_nxt;
      r_dv_d    <= I_gmii_dv;
      if (!I_gmii_dv) r_armed <= 1'b1;

      r_tx_en <= w_emit;
      if (w_emit) r_tx_data <= w_dl_data;

      if (r_state != S_PAY) begin
        r_emit_cnt <= '0;
      end else if (w_emit && (r_emit_cnt != '1)) begin
        r_emit_cnt <= r_emit_cnt + 1'b1;
      end

      r_done <= w_end_ok;
      if (w_end_ok || w_end_runt) r_frame_len <= r_emit_cnt;

      // Clear has priority; an increment landing on the same edge is lost.
      if (I_state_clr) begin
        r_frame_cnt   <= '0;
        r_payload_cnt <= '0;
        r_err_cnt     <= '0;
      end else begin
        if (w_end_ok)  r_frame_cnt   <= r_frame_cnt + 1'b1;
        if (w_emit)    r_payload_cnt <= r_payload_cnt + 1'b1;
        if (w_err_inc) r_err_cnt     <= r_err_cnt + 1'b1;
      end
    end
  end

  assign O_tx_data     = r_tx_data;
  assign O_tx_data_en  = r_tx_en;
  assign O_frame_done  = r_done;
  assign O_frame_len   = r_frame_len;
  assign O_frame_cnt   = r_frame_cnt;
  assign O_payload_cnt = r_payload_cnt;
  assign O_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_lzw_gmii_payload_extract.sv
module tb_lzw_gmii_payload_extract;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [7:0]  gdata;
  logic        gdv;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        done;
  logic [15:0] flen;
  logic [31:0] fcnt;
  logic [31:0] pcnt;
  logic [15:0] ecnt;

  always #2 clk = ~clk;

  lzw_gmii_payload_extract dut (
    .I_sys_clk     (clk),
    .I_sys_rst     (rst),
    .I_state_clr   (clr),
    .I_gmii_data   (gdata),
    .I_gmii_dv     (gdv),
    .O_tx_data     (tx_data),
    .O_tx_data_en  (tx_en),
    .O_frame_done  (done),
    .O_frame_len   (flen),
    .O_frame_cnt   (fcnt),
    .O_payload_cnt (pcnt),
    .O_err_cnt     (ecnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         len_q[$];
  logic [7:0] fr[$];
  logic [7:0] pl[$];
  int         exp_frames = 0;
  int         exp_pay    = 0;
  int         exp_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output byte and every done pulse must match the head
  // of the expectation queues.
  always @(negedge clk) begin
    logic [7:0] eb;
    int         el;
    if (!rst) begin
      if (tx_en) begin
        chk("tx_en_expected", 32'(tx_en), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(eb));
        end
      end
      if (done) begin
        chk("done_expected", 32'(done), 32'(len_q.size() != 0));
        if (len_q.size() != 0) begin
          el = len_q.pop_front();
          chk("frame_len", 32'(flen), 32'(el));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nominal_pl();
    pl = {8'h0A, 8'h0B, 8'h0A, 8'h0B, 8'h0C, 8'h0B, 8'h0A, 8'h0B, 8'h0C};
    repeat (11) pl.push_back(8'h0C);
  endtask

  task automatic make_frame(input int npre, input int nfcs);
    fr.delete();
    repeat (npre) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    repeat (6) fr.push_back(8'hDA);
    repeat (6) fr.push_back(8'h5A);
    foreach (pl[i]) fr.push_back(pl[i]);
    repeat (nfcs) fr.push_back(8'h04);
  endtask

  task automatic expect_bytes();
    foreach (pl[i]) exp_q.push_back(pl[i]);
    len_q.push_back(pl.size());
  endtask

  task automatic expect_good();
    expect_bytes();
    exp_frames++;
    exp_pay += pl.size();
  endtask

  task automatic drive(input int n, input int gap, input bit clr_end);
    for (int i = 0; i < n && i < fr.size(); i++) begin
      gdata = fr[i];
      gdv   = 1'b1;
      tick();
    end
    gdv   = 1'b0;
    gdata = 8'h00;
    clr   = clr_end;
    tick();
    clr   = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic drain(input string tag);
    repeat (8) tick();
    chk({tag, "_q_left"}, 32'(exp_q.size() + len_q.size()), 32'd0);
    chk({tag, "_frame_cnt"}, fcnt, 32'(exp_frames));
    chk({tag, "_payload_cnt"}, pcnt, 32'(exp_pay));
    chk({tag, "_err_cnt"}, 32'(ecnt), 32'(exp_err));
  endtask

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    gdata = 8'h00;
    gdv   = 1'b0;
    repeat (3) tick();
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_counts", fcnt | pcnt | 32'(ecnt) | 32'(flen) | 32'(tx_data), 32'd0);

    // dv already high when reset releases: must wait for it to drop.
    gdata = 8'h55;
    gdv   = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    gdv = 1'b0;
    repeat (2) tick();
    chk("dv_hi_out_of_rst_err", 32'(ecnt), 32'd0);

    // 1: nominal frame
    nominal_pl();
    make_frame(7, 4);
    expect_good();
    drive(fr.size(), 1, 1'b0);
    drain("t1");

    // 2: 20 back-to-back frames, one idle cycle between
    for (int f = 0; f < 20; f++) begin
      make_frame(7, 4);
      expect_good();
      drive(fr.size(), 1, 1'b0);
    end
    drain("t2");

    // 3: runt (3 bytes after header), then 1-byte payload
    pl.delete();
    make_frame(7, 3);
    exp_err++;
    drive(fr.size(), 1, 1'b0);
    pl = {8'h3C};
    make_frame(7, 4);
    expect_good();
    drive(fr.size(), 1, 1'b0);
    drain("t3");

    // 4: bad preamble, then dv drop in header, then a good frame
    fr = {8'h55, 8'h55, 8'hAA, 8'h11, 8'h22};
    exp_err++;
    drive(fr.size(), 1, 1'b0);
    nominal_pl();
    make_frame(7, 4);
    exp_err++;
    drive(7 + 1 + 5, 1, 1'b0);
    expect_good();
    drive(fr.size(), 1, 1'b0);
    drain("t4");

    // preamble length boundaries and a random payload
    make_frame(8, 4);
    exp_err++;
    drive(fr.size(), 1, 1'b0);
    make_frame(1, 4);
    expect_good();
    drive(fr.size(), 1, 1'b0);
    pl.delete();
    for (int i = 0; i < 37; i++) pl.push_back(8'($urandom_range(255, 0)));
    make_frame(3, 4);
    expect_good();
    drive(fr.size(), 2, 1'b0);
    drain("bnd");

    // 5: reset during payload of frame 1; frame 2 must pass intact
    nominal_pl();
    make_frame(7, 4);
    exp_q.push_back(pl[0]);
    exp_q.push_back(pl[1]);
    for (int i = 0; i < 26; i++) begin
      gdata = fr[i];
      gdv   = 1'b1;
      tick();
    end
    tick();
    chk("t5_q_before_rst", 32'(exp_q.size()), 32'd0);
    rst   = 1'b1;
    gdata = fr[27];
    tick();
    chk("t5_rst_tx_en", 32'(tx_en), 32'd0);
    chk("t5_rst_counts", fcnt | pcnt | 32'(ecnt), 32'd0);
    rst = 1'b0;
    exp_frames = 0;
    exp_pay    = 0;
    exp_err    = 0;
    for (int i = 28; i < fr.size(); i++) begin
      gdata = fr[i];
      tick();
    end
    gdv   = 1'b0;
    gdata = 8'h00;
    tick();
    make_frame(7, 4);
    expect_good();
    drive(fr.size(), 1, 1'b0);
    drain("t5");

    // 6: counter clear coincident with frame end
    make_frame(7, 4);
    expect_bytes();
    drive(fr.size(), 1, 1'b1);
    exp_frames = 0;
    exp_pay    = 0;
    exp_err    = 0;
    drain("t6_clr");
    expect_good();
    drive(fr.size(), 1, 1'b0);
    drain("t6_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
